// File: rtl/draw_bg_starfield_if.sv
// VGA timing/colour bundle shared by the drawing pipeline stages.
// The "in" view omits rgb because background generators ignore upstream colour.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_bg_starfield.sv
// Parallax starfield background: per-layer hashed star test with per-frame downward scroll.
// Two-stage pipeline; vga_out timing is vga_in delayed by exactly two clocks.
module draw_bg_starfield #(
    parameter int          LAYERS        = 3,
    parameter int          DENSITY_BITS  = 6,
    parameter logic [11:0] BLANK_RGB     = 12'h8_8_8,
    parameter logic [11:0] BG_RGB        = 12'h0_0_1,
    parameter logic [11:0] STAR_RGB_NEAR = 12'hf_f_f,
    parameter logic [11:0] STAR_RGB_FAR  = 12'h6_6_8
) (
    input  logic clk,
    input  logic rst,
    input  logic scroll_en,
    vga_if.in    vga_in,
    vga_if.out   vga_out
);

    // Top DENSITY_BITS bits set; zero width yields an empty mask, so every pixel is lit.
    localparam logic [15:0] DENSITY_MASK = 16'(32'h0000_FFFF << (16 - DENSITY_BITS));

    function automatic logic [15:0] layer_seed(input int k);
        logic [31:0] dbl;
        dbl = {16'hA5C3, 16'hA5C3} << ((4 * k) % 16);
        return dbl[31:16];
    endfunction

    logic        r_vblnk_prev;
    logic [9:0]  r_off [LAYERS];

    logic [15:0] r_s1_v [LAYERS];
    logic [10:0] r_s1_hcount;
    logic [10:0] r_s1_vcount;
    logic        r_s1_hsync;
    logic        r_s1_vsync;
    logic        r_s1_hblnk;
    logic        r_s1_vblnk;

    logic [10:0] r_s2_hcount;
    logic [10:0] r_s2_vcount;
    logic        r_s2_hsync;
    logic        r_s2_vsync;
    logic        r_s2_hblnk;
    logic        r_s2_vblnk;
    logic [11:0] r_s2_rgb;

    logic              w_tick;
    logic [15:0]       w_v [LAYERS];
    logic [LAYERS-1:0] w_lit;
    logic [11:0]       w_rgb;

    assign w_tick = vga_in.vblnk & ~r_vblnk_prev;

    for (genvar g = 0; g < LAYERS; g++) begin : g_layer
        logic [7:0]  w_y;
        logic [15:0] w_m1;
        logic [15:0] w_m2;

        // Only the low 8 bits of y feed the hash, so the 10-bit subtraction is not needed.
        assign w_y      = vga_in.vcount[7:0] - r_off[g][7:0];
        assign w_v[g]   = {w_y, vga_in.hcount[7:0]} ^ layer_seed(g);
        assign w_m1     = r_s1_v[g] ^ (r_s1_v[g] >> 7);
        assign w_m2     = w_m1 ^ (w_m1 << 9);
        assign w_lit[g] = (w_m2 & DENSITY_MASK) == DENSITY_MASK;
    end

    // Ascending scan so the highest-index (nearest) lit layer wins.
    always_comb begin
        w_rgb = BG_RGB;
        for (int k = 0; k < LAYERS; k++) begin
            if (w_lit[k]) begin
                w_rgb = (k == LAYERS - 1) ? STAR_RGB_NEAR : STAR_RGB_FAR;
            end
        end
        if (r_s1_hblnk | r_s1_vblnk) begin
            w_rgb = BLANK_RGB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vblnk_prev <= 1'b0;
            for (int k = 0; k < LAYERS; k++) begin
                r_off[k]  <= '0;
                r_s1_v[k] <= '0;
            end
            r_s1_hcount <= '0;
            r_s1_vcount <= '0;
            r_s1_hsync  <= 1'b0;
            r_s1_vsync  <= 1'b0;
            r_s1_hblnk  <= 1'b0;
            r_s1_vblnk  <= 1'b0;
            r_s2_hcount <= '0;
            r_s2_vcount <= '0;
            r_s2_hsync  <= 1'b0;
            r_s2_vsync  <= 1'b0;
            r_s2_hblnk  <= 1'b0;
            r_s2_vblnk  <= 1'b0;
            r_s2_rgb    <= '0;
        end else begin
            r_vblnk_prev <= vga_in.vblnk;
            for (int k = 0; k < LAYERS; k++) begin
                if (w_tick && scroll_en) begin
                    r_off[k] <= r_off[k] + 10'(k + 1);
                end
                r_s1_v[k] <= w_v[k];
            end
            r_s1_hcount <= vga_in.hcount;
            r_s1_vcount <= vga_in.vcount;
            r_s1_hsync  <= vga_in.hsync;
            r_s1_vsync  <= vga_in.vsync;
            r_s1_hblnk  <= vga_in.hblnk;
            r_s1_vblnk  <= vga_in.vblnk;
            r_s2_hcount <= r_s1_hcount;
            r_s2_vcount <= r_s1_vcount;
            r_s2_hsync  <= r_s1_hsync;
            r_s2_vsync  <= r_s1_vsync;
            r_s2_hblnk  <= r_s1_hblnk;
            r_s2_vblnk  <= r_s1_vblnk;
            r_s2_rgb    <= w_rgb;
        end
    end

    assign vga_out.hcount = r_s2_hcount;
    assign vga_out.vcount = r_s2_vcount;
    assign vga_out.hsync  = r_s2_hsync;
    assign vga_out.vsync  = r_s2_vsync;
    assign vga_out.hblnk  = r_s2_hblnk;
    assign vga_out.vblnk  = r_s2_vblnk;
    assign vga_out.rgb    = r_s2_rgb;

endmodule

// File: tb/tb_draw_bg_starfield.sv
// Bench for draw_bg_starfield: four parameterisations share one input stream and are
// compared cycle by cycle against an arithmetic reference of the star hash and scroll.
module tb_draw_bg_starfield;

    logic clk = 1'b0;
    logic rst;
    logic scroll_en;

    always #5 clk = ~clk;

    vga_if vin ();
    vga_if vout_a ();
    vga_if vout_b ();
    vga_if vout_c ();
    vga_if vout_d ();

    draw_bg_starfield dut_a (
        .clk(clk), .rst(rst), .scroll_en(scroll_en), .vga_in(vin), .vga_out(vout_a));
    draw_bg_starfield #(.LAYERS(3), .DENSITY_BITS(0)) dut_b (
        .clk(clk), .rst(rst), .scroll_en(scroll_en), .vga_in(vin), .vga_out(vout_b));
    draw_bg_starfield #(.LAYERS(1), .DENSITY_BITS(6)) dut_c (
        .clk(clk), .rst(rst), .scroll_en(scroll_en), .vga_in(vin), .vga_out(vout_c));
    draw_bg_starfield #(.LAYERS(1), .DENSITY_BITS(0)) dut_d (
        .clk(clk), .rst(rst), .scroll_en(scroll_en), .vga_in(vin), .vga_out(vout_d));

    logic [37:0] obs_a, obs_b, obs_c, obs_d;
    assign obs_a = {vout_a.hcount, vout_a.vcount, vout_a.hsync, vout_a.vsync, vout_a.hblnk, vout_a.vblnk, vout_a.rgb};
    assign obs_b = {vout_b.hcount, vout_b.vcount, vout_b.hsync, vout_b.vsync, vout_b.hblnk, vout_b.vblnk, vout_b.rgb};
    assign obs_c = {vout_c.hcount, vout_c.vcount, vout_c.hsync, vout_c.vsync, vout_c.hblnk, vout_c.vblnk, vout_c.rgb};
    assign obs_d = {vout_d.hcount, vout_d.vcount, vout_d.hsync, vout_d.vsync, vout_d.hblnk, vout_d.vblnk, vout_d.rgb};

    localparam int MAXC = 8192;
    bit          rec_rst [MAXC];
    logic [37:0] exp_a [MAXC];
    logic [37:0] exp_b [MAXC];
    logic [37:0] exp_c [MAXC];
    logic [37:0] exp_d [MAXC];

    int cyc      = 0;
    int n_assert = 0;
    int n_fail   = 0;
    int m_off [4];
    bit m_prev;

    function automatic int seed_of(int k);
        int x, s;
        x = 'hA5C3;
        s = 4 * k;
        if (s == 0) return x;
        return ((x << s) | (x >> (16 - s))) & 'hFFFF;
    endfunction

    function automatic logic [11:0] model_rgb(int layers, int db, int h, int vc, bit blank);
        logic [11:0] res;
        int y, val, m1, m2;
        if (blank) return 12'h888;
        res = 12'h001;
        for (int k = 0; k < layers; k++) begin
            y   = ((vc % 1024) - m_off[k] + 1024) % 1024;
            val = ((y % 256) * 256 + (h % 256)) ^ seed_of(k);
            m1  = val ^ (val >> 7);
            m2  = (m1 ^ (m1 * 512)) % 65536;
            if (db == 0 || (m2 >> (16 - db)) == (1 << db) - 1)
                res = (k == layers - 1) ? 12'hfff : 12'h668;
        end
        return res;
    endfunction

    function automatic logic [37:0] pack(logic [10:0] h, logic [10:0] v, logic hs, logic vs,
                                         logic hb, logic vb, logic [11:0] rgb);
        return {h, v, hs, vs, hb, vb, rgb};
    endfunction

    task automatic check(string tag, logic [37:0] obs, logic [37:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic chk_off(int k, int expv);
        n_assert++;
        assert (dut_a.r_off[k] === 10'(expv)) else begin
            n_fail++;
            $error("FAIL off_%0d cyc=%0d observed=%0d expected=%0d", k, cyc, dut_a.r_off[k], expv);
        end
    endtask

    task automatic step(bit r, bit en, int h, int vc, bit hs, bit vs, bit hb, bit vb);
        int hm, vm;
        if (cyc >= 1 && rec_rst[cyc-1]) begin
            check("rst_a", obs_a, '0);
            check("rst_b", obs_b, '0);
            check("rst_c", obs_c, '0);
            check("rst_d", obs_d, '0);
        end else if (cyc >= 2 && !rec_rst[cyc-2]) begin
            check("px_a", obs_a, exp_a[cyc-2]);
            check("px_b", obs_b, exp_b[cyc-2]);
            check("px_c", obs_c, exp_c[cyc-2]);
            check("px_d", obs_d, exp_d[cyc-2]);
        end
        hm = h % 2048;
        vm = vc % 2048;
        rst         = r;
        scroll_en   = en;
        vin.hcount  = 11'(hm);
        vin.vcount  = 11'(vm);
        vin.hsync   = hs;
        vin.vsync   = vs;
        vin.hblnk   = hb;
        vin.vblnk   = vb;
        vin.rgb     = 12'($urandom);
        rec_rst[cyc] = r;
        if (r) begin
            for (int k = 0; k < 4; k++) m_off[k] = 0;
            m_prev = 1'b0;
        end else begin
            exp_a[cyc] = pack(11'(hm), 11'(vm), hs, vs, hb, vb, model_rgb(3, 6, hm, vm, hb | vb));
            exp_b[cyc] = pack(11'(hm), 11'(vm), hs, vs, hb, vb, model_rgb(3, 0, hm, vm, hb | vb));
            exp_c[cyc] = pack(11'(hm), 11'(vm), hs, vs, hb, vb, model_rgb(1, 6, hm, vm, hb | vb));
            exp_d[cyc] = pack(11'(hm), 11'(vm), hs, vs, hb, vb, model_rgb(1, 0, hm, vm, hb | vb));
            if (vb && !m_prev && en)
                for (int k = 0; k < 4; k++) m_off[k] = (m_off[k] + k + 1) % 1024;
            m_prev = vb;
        end
        @(negedge clk);
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    task automatic rand_px(int n, int vb_one_in);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'($urandom % 2), $urandom % 2048, $urandom % 2048,
                 1'($urandom % 2), 1'($urandom % 2), ($urandom % 8) == 0,
                 vb_one_in > 0 && ($urandom % vb_one_in) == 0);
    endtask

    task automatic frame_tick(bit en);
        step(1'b0, en, $urandom % 2048, $urandom % 2048, 0, 1, 1, 1);
        step(1'b0, 1'($urandom % 2), $urandom % 2048, $urandom % 2048, 0, 1, 1, 1);
        step(1'b0, 1'($urandom % 2), $urandom % 2048, $urandom % 2048, 0, 0, 0, 0);
        step(1'b0, 1'($urandom % 2), $urandom % 2048, $urandom % 2048, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) step(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);

        // hash pixel at origin, then a horizontal-blank pixel
        step(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b0, 5, 7, 1, 0, 1, 0);
        n_assert++;
        assert (vout_c.rgb === 12'h001) else begin
            n_fail++; $error("FAIL hash_c observed=%h expected=%h", vout_c.rgb, 12'h001);
        end
        n_assert++;
        assert (vout_b.rgb === 12'hfff && vout_d.rgb === 12'hfff) else begin
            n_fail++; $error("FAIL testmode observed=%h/%h expected=fff", vout_b.rgb, vout_d.rgb);
        end
        step(1'b0, 1'b0, 9, 9, 0, 0, 0, 0);
        n_assert++;
        assert (vout_a.rgb === 12'h888 && vout_a.hblnk === 1'b1 && vout_a.hcount === 11'd5
                && vout_a.vcount === 11'd7 && vout_a.hsync === 1'b1) else begin
            n_fail++; $error("FAIL hblnk_latency observed=%h expected=888", vout_a.rgb);
        end

        rand_px(200, 0);

        repeat (3) frame_tick(1'b1);
        chk_off(0, 3);
        chk_off(1, 6);
        chk_off(2, 9);
        frame_tick(1'b0);
        chk_off(0, 3);
        chk_off(1, 6);
        chk_off(2, 9);

        rand_px(300, 0);
        rand_px(1500, 6);

        repeat (2) step(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
        repeat (342) frame_tick(1'b1);
        chk_off(0, 342);
        chk_off(1, 684);
        chk_off(2, 2);
        rand_px(300, 0);

        // one-cycle reset in the middle of an active line
        step(1'b1, 1'b1, 100, 200, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) chk_off(k, 0);
        rand_px(200, 0);

        // vblnk already high as reset releases: tick on the first cycle
        step(1'b1, 1'b1, 0, 0, 0, 1, 1, 1);
        step(1'b0, 1'b1, 0, 0, 0, 1, 1, 1);
        chk_off(0, 1);
        chk_off(1, 2);
        chk_off(2, 3);
        rand_px(50, 0);
        repeat (3) step(1'b0, 1'b0, 1, 1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_bg_starfield.md
DRAW_BG_STARFIELD -- requirements
Module: draw_bg_starfield

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, ports named clk and rst.
REQ-002 Parameter LAYERS, default 3, number of star layers, legal range 1..4.
REQ-003 Parameter DENSITY_BITS, default 6, star test width, legal range 0..8; 0 makes every pixel a star (test mode).
REQ-004 Parameter BLANK_RGB, default 12'h8_8_8, colour during blanking.
REQ-005 Parameter BG_RGB, default 12'h0_0_1, colour of empty space.
REQ-006 Parameter STAR_RGB_NEAR, default 12'hf_f_f, colour of layer LAYERS-1.
REQ-007 Parameter STAR_RGB_FAR, default 12'h6_6_8, colour of layers 0..LAYERS-2.
REQ-008 Port clk, input, 1, pixel clock.
REQ-009 Port rst, input, 1, synchronous active-high reset.
REQ-010 Port scroll_en, input, 1, enables per-frame layer scrolling when high.
REQ-011 Port vga_in, vga_if.in, bundle: hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk; rgb is ignored.
REQ-012 Port vga_out, vga_if.out, bundle: timing delayed to match rgb, rgb[11:0] generated.

Function
REQ-013 The block SHALL hold one 10-bit scroll offset off_k per layer k = 0..LAYERS-1.
REQ-014 A frame tick SHALL be a rising edge of vga_in.vblnk, i.e. registered previous vblnk = 0 and current = 1.
REQ-015 On a frame tick with scroll_en = 1, each off_k SHALL become (off_k + k + 1) mod 1024; with scroll_en = 0, offsets SHALL hold.
REQ-016 Offset wrap from 1023 upward SHALL be modulo 1024, with no saturation.
REQ-017 Per layer and pixel, y_k SHALL be (vcount[9:0] - off_k) mod 1024, so stars move down the screen.
REQ-018 v SHALL be {y_k[7:0], hcount[7:0]} XOR SEED_k, where SEED_k = 16'hA5C3 rotated left by 4*k.
REQ-019 m1 SHALL be v XOR (v >> 7).
REQ-020 m2 SHALL be m1 XOR (m1 << 9), truncated to 16 bits.
REQ-021 Layer k SHALL be lit iff m2[15 -: DENSITY_BITS] is all ones; with DENSITY_BITS = 0 it is always lit.
REQ-022 rgb priority SHALL be:
- hblnk or vblnk: BLANK_RGB;
- else highest-index lit layer: STAR_RGB_NEAR if the index is LAYERS-1, else STAR_RGB_FAR;
- else BG_RGB.
REQ-023 Pipeline latency SHALL be exactly 2 clk:
- stage 1 registers the y_k/v calculation and the timing signals;
- stage 2 registers rgb and the timing signals.
REQ-024 All vga_out timing fields SHALL equal the vga_in fields of 2 cycles earlier, bit-exact.
REQ-025 An offset update on a frame tick SHALL take effect for pixels entering stage 1 on the following cycle; no mid-line tearing, since the tick occurs only in vblank.
REQ-026 A frame tick coincident with a scroll_en change SHALL use the scroll_en value sampled on that same cycle.

Reset
REQ-027 While rst = 1, all vga_out fields, both pipeline stages, the previous-vblnk register and every off_k SHALL be 0 on the next clk edge.
REQ-028 Reset asserted mid-frame SHALL discard in-flight pixels; the first valid output appears 2 cycles after rst deasserts.
REQ-029 Immediately after reset, prev vblnk = 0, so a vblnk already high when rst deasserts SHALL produce a frame tick on the first cycle.

Verification
REQ-030 Latency and blanking: hblnk=1 at cycle n -> vga_out.rgb = 12'h888 and vga_out.hblnk = 1 at cycle n+2, with hcount, vcount and syncs delayed by 2.
REQ-031 Test mode: DENSITY_BITS=0, LAYERS=3, active pixel -> rgb = 12'hfff; LAYERS=1 also gives 12'hfff.
REQ-032 Hash check:
- stimulus: LAYERS=1, DENSITY_BITS=6, offsets 0, hcount=0, vcount=0;
- expected: v=16'hA5C3, m1=16'hA488, m2=16'hB488, not lit;
- required response: rgb = 12'h001.
REQ-033 Scrolling: scroll_en=1 for 3 frame ticks with LAYERS=3 -> off_0=3, off_1=6, off_2=9; scroll_en=0 on a 4th tick -> unchanged.
REQ-034 Wrap: off_2 preset by 342 ticks (1026 mod 1024) -> off_2 = 2.
REQ-035 Reset: rst pulsed mid-line for 1 cycle -> outputs 0 on the next cycle, offsets 0, and the lit pattern equal to the first frame after power-up.
